// File: rtl/dispatch_ctrl.sv
// Dispatch controller: one-entry holding register between rename and the RS/ROB.
// Optional performance counters are built only when DISPATCH_PERF_CNT_EN is defined.
package dispatch_pkg;
  typedef struct packed {
    logic [6:0] opcode;
    logic [5:0] prd;
    logic [5:0] prs1;
    logic [5:0] prs2;
    logic [4:0] rob_tag;
  } renamed_instr_t;
endpackage

module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  input  renamed_instr_t in_instr,
  input  logic [1:0]     in_fu_type,
  output logic           in_ready,
  input  logic           alu_full,
  input  logic           br_full,
  input  logic           lsu_full,
  input  logic           rob_full,
  input  logic           rob_empty,
  output logic           alu_dispatch_en,
  output logic           br_dispatch_en,
  output logic           lsu_dispatch_en,
  output logic           rob_alloc_en,
  output renamed_instr_t dispatch_instr
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_rs_cnt,
  output logic [CNT_W-1:0] stall_rob_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, HELD, SERIAL_WAIT} state_t;

  state_t         state_reg;
  renamed_instr_t instr_reg;
  logic [1:0]     fu_reg;

  logic       target_full;
  logic       fire;
  logic       go;
  logic       accept;
  logic [1:0] target;
  logic [2:0] dispatch_vec;

  // Serial instructions execute on the ALU, so they share its RS and full flag.
  assign target = (fu_reg == 2'd3) ? 2'd0 : fu_reg;

  always_comb begin
    target_full = alu_full;
    case (target)
      2'd1:    target_full = br_full;
      2'd2:    target_full = lsu_full;
      default: target_full = alu_full;
    endcase
  end

  always_comb begin
    fire = 1'b0;
    case (state_reg)
      HELD:        fire = !target_full && !rob_full;
      SERIAL_WAIT: fire = rob_empty && !alu_full && !rob_full;
      default:     fire = 1'b0;
    endcase
  end

  assign go       = fire && !flush && !rst;
  assign in_ready = !rst && !flush && ((state_reg == EMPTY) || fire);
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_strobe
      assign dispatch_vec[gi] = go && (target == 2'(gi));
    end
  endgenerate

  assign alu_dispatch_en = dispatch_vec[0];
  assign br_dispatch_en  = dispatch_vec[1];
  assign lsu_dispatch_en = dispatch_vec[2];
  assign rob_alloc_en    = go;
  assign dispatch_instr  = instr_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_reg <= EMPTY;
    end else if (accept) begin
      instr_reg <= in_instr;
      fu_reg    <= in_fu_type;
      state_reg <= (in_fu_type == 2'd3) ? SERIAL_WAIT : HELD;
    end else if (fire) begin
      state_reg <= EMPTY;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic stalled;
  logic stall_rs;
  logic stall_rob;

  // A full RS is blamed first; any remaining stall is down to the ROB.
  assign stalled   = (state_reg != EMPTY) && !fire && !flush;
  assign stall_rs  = stalled && target_full;
  assign stall_rob = stalled && !target_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_rs_cnt  <= '0;
      stall_rob_cnt <= '0;
    end else begin
      if (stall_rs && !(&stall_rs_cnt))
        stall_rs_cnt <= stall_rs_cnt + 1'b1;
      if (stall_rob && !(&stall_rob_cnt))
        stall_rob_cnt <= stall_rob_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Testbench for dispatch_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model of the holding slot.
module tb_dispatch_ctrl;
  import dispatch_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic           clk = 1'b0;
  logic           rst, flush, in_valid;
  renamed_instr_t in_instr;
  logic [1:0]     in_fu_type;
  logic           in_ready;
  logic           alu_full, br_full, lsu_full, rob_full, rob_empty;
  logic           alu_dispatch_en, br_dispatch_en, lsu_dispatch_en, rob_alloc_en;
  renamed_instr_t dispatch_instr;
`ifdef DISPATCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_rs_cnt, stall_rob_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  dispatch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_fu_type(in_fu_type),
    .in_ready(in_ready),
    .alu_full(alu_full), .br_full(br_full), .lsu_full(lsu_full),
    .rob_full(rob_full), .rob_empty(rob_empty),
    .alu_dispatch_en(alu_dispatch_en), .br_dispatch_en(br_dispatch_en),
    .lsu_dispatch_en(lsu_dispatch_en), .rob_alloc_en(rob_alloc_en),
    .dispatch_instr(dispatch_instr)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .stall_rs_cnt(stall_rs_cnt), .stall_rob_cnt(stall_rob_cnt)
`endif
  );

  function automatic logic [3:0] strobes();
    return {rob_alloc_en, lsu_dispatch_en, br_dispatch_en, alu_dispatch_en};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model: the slot is a queue of depth <= 1 ----------------
  typedef struct {
    renamed_instr_t instr;
    logic [1:0]     fu;
  } slot_t;

  slot_t slot_q[$];
  int    m_rs = 0, m_rob = 0;
  bit    model_ok = 0;

  always @(negedge clk) begin : cmp
    bit       held, serial, can_go, blk_rs, exp_ready;
    int       unit;
    logic [3:0] exp_str;
    logic [2:0] full_arr;
    full_arr  = {lsu_full, br_full, alu_full};
    held      = (slot_q.size() != 0);
    serial    = held && (slot_q[0].fu == 2'd3);
    unit      = held ? (serial ? 0 : int'(slot_q[0].fu)) : 0;
    can_go    = held && (serial ? (rob_empty && !alu_full && !rob_full)
                                : (!full_arr[unit] && !rob_full));
    blk_rs    = held && full_arr[unit];
    exp_ready = !rst && !flush && (!held || can_go);
    exp_str   = 4'b0;
    if (can_go && !rst && !flush) exp_str = 4'b1000 | (4'b0001 << unit);

    if (model_ok || rst) begin
      check("model_in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      check("model_strobes", {28'b0, strobes()}, {28'b0, exp_str});
      if (held && model_ok)
        check("model_dispatch_instr", {2'b0, dispatch_instr}, {2'b0, slot_q[0].instr});
`ifdef DISPATCH_PERF_CNT_EN
      if (model_ok) begin
        check("model_stall_rs_cnt", {28'b0, stall_rs_cnt}, m_rs);
        check("model_stall_rob_cnt", {28'b0, stall_rob_cnt}, m_rob);
      end
`endif
    end
    if (rob_alloc_en)
      $display("cycle %0d dispatch strobes=%b instr=%h", cycle, strobes(), dispatch_instr);

    if (rst) begin
      slot_q.delete();
      m_rs = 0;
      m_rob = 0;
      model_ok = 1;
    end else begin
      if (held && !can_go && !flush) begin
        if (blk_rs) begin
          if (m_rs != CNT_MAX) m_rs++;
        end else if (m_rob != CNT_MAX) m_rob++;
      end
      if (flush) slot_q.delete();
      else begin
        if (can_go) void'(slot_q.pop_front());
        if (in_valid && exp_ready) slot_q.push_back('{in_instr, in_fu_type});
      end
    end
    cycle++;
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit r, input bit f, input bit v, input logic [1:0] fu,
                        input bit af, input bit bf, input bit lf, input bit rf, input bit re);
    rst = r; flush = f; in_valid = v; in_fu_type = fu;
    in_instr = renamed_instr_t'($urandom);
    alu_full = af; br_full = bf; lsu_full = lf; rob_full = rf; rob_empty = re;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_strobes", {28'b0, strobes()}, 0);
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 1);
  endtask

  logic [1:0] stream_fu [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [3:0] stream_exp[5] = '{4'b0000, 4'b1001, 4'b1010, 4'b1100, 4'b1001};

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();

    // Back-to-back stream ALU, BR, LSU, ALU.
    for (int k = 0; k < 5; k++) begin
      step(); set_in(0, 0, k < 4, (k < 4) ? stream_fu[k] : 2'd0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("stream_strobes", {28'b0, strobes()}, {28'b0, stream_exp[k]});
      if (k < 4) check("stream_in_ready", {31'b0, in_ready}, 1);
    end

    // LSU held against a full RS for three cycles.
    do_reset();
    step(); set_in(0, 0, 1, 2'd2, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(); set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
      @(negedge clk);
      check("rs_stall_strobes", {28'b0, strobes()}, 0);
      check("rs_stall_in_ready", {31'b0, in_ready}, 0);
    end
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("rs_release_strobes", {28'b0, strobes()}, 4'b1100);
`ifdef DISPATCH_PERF_CNT_EN
    check("rs_stall_cnt", {28'b0, stall_rs_cnt}, 3);
`endif

    // Serial instruction waiting for an empty ROB.
    do_reset();
    step(); set_in(0, 0, 1, 2'd3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("serial_wait_strobes", {28'b0, strobes()}, 0);
      check("serial_wait_in_ready", {31'b0, in_ready}, 0);
    end
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("serial_release_strobes", {28'b0, strobes()}, 4'b1001);
`ifdef DISPATCH_PERF_CNT_EN
    check("serial_rob_cnt", {28'b0, stall_rob_cnt}, 5);
`endif

    // Flush coinciding with a fire-eligible ALU instruction.
    step(); set_in(0, 0, 1, 2'd0, 0, 0, 0, 0, 1);
    step(); set_in(0, 1, 1, 2'd1, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("flush_strobes", {28'b0, strobes()}, 0);
    check("flush_in_ready", {31'b0, in_ready}, 0);
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("after_flush_in_ready", {31'b0, in_ready}, 1);
    check("after_flush_strobes", {28'b0, strobes()}, 0);

    // Reset while an LSU instruction is held.
    step(); set_in(0, 0, 1, 2'd2, 0, 0, 1, 0, 1);
    step(); set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      step(); set_in(1, 0, 1, 2'd0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("mid_rst_strobes", {28'b0, strobes()}, 0);
      check("mid_rst_in_ready", {31'b0, in_ready}, 0);
    end
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("mid_rst_release_ready", {31'b0, in_ready}, 1);
    check("mid_rst_release_strobes", {28'b0, strobes()}, 0);
`ifdef DISPATCH_PERF_CNT_EN
    check("mid_rst_rs_cnt", {28'b0, stall_rs_cnt}, 0);
    check("mid_rst_rob_cnt", {28'b0, stall_rob_cnt}, 0);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int k = 0; k < 600; k++) begin
      step();
      set_in($urandom_range(99) < 2, $urandom_range(99) < 5, $urandom_range(99) < 70,
             2'($urandom_range(3)),
             $urandom_range(99) < 30, $urandom_range(99) < 30, $urandom_range(99) < 30,
             $urandom_range(99) < 25, $urandom_range(99) < 60);
    end
    step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
